// File: rtl/spi_pkg.sv
// Shared types and default widths for the SPI register-access initiator.
package spi_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_state_e;

    localparam int SPI_ADDR_WIDTH = 8;
    localparam int SPI_DATA_WIDTH = 16;
    localparam int SPI_RD_BIT     = SPI_ADDR_WIDTH - 1;

endpackage

// File: rtl/spi_master_sync_2ff.sv
// Two-flop synchronizer for the asynchronous responder data line.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI initiator: one {addr, data} frame per accepted start, MSB first;
// addr MSB set makes it a read whose data phase is captured from spi_miso.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int ADDR_WIDTH = SPI_ADDR_WIDTH,
    parameter int CLK_DIV    = 8,
    parameter int CS_SETUP   = 4,
    parameter int CS_HOLD    = 4,
    parameter int CS_GAP     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] txdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rxdata,
    output logic                  spi_cs,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int N      = ADDR_WIDTH + DATA_WIDTH;
    localparam int RD_BIT = (ADDR_WIDTH == SPI_ADDR_WIDTH) ? SPI_RD_BIT : ADDR_WIDTH - 1;
    localparam int HW     = $clog2(CLK_DIV);
    localparam int BW     = $clog2(N + 1);
    localparam int PMAX   = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                                 : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int PW     = $clog2(PMAX + 1);

    spi_state_e            state, state_nx;
    logic [HW-1:0]         hcnt, hcnt_nx;
    logic [BW-1:0]         bcnt, bcnt_nx;
    logic [PW-1:0]         pcnt, pcnt_nx;
    logic [N-1:0]          shreg, shreg_nx;
    logic [DATA_WIDTH-1:0] rxsh, rxsh_nx, rxdata_nx;
    logic                  is_read, is_read_nx;
    logic                  cs_nx, sck_nx, mosi_nx, busy_nx, done_nx;
    logic                  miso_s;

    sync_2ff u_miso_sync (
        .clk (clk),
        .rst (rst),
        .d   (spi_miso),
        .q   (miso_s)
    );

    always_comb begin
        state_nx   = state;
        hcnt_nx    = hcnt;
        bcnt_nx    = bcnt;
        pcnt_nx    = pcnt;
        shreg_nx   = shreg;
        rxsh_nx    = rxsh;
        rxdata_nx  = rxdata;
        is_read_nx = is_read;
        cs_nx      = spi_cs;
        sck_nx     = spi_sck;
        mosi_nx    = spi_mosi;
        busy_nx    = busy;
        done_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    shreg_nx   = {addr, txdata};
                    is_read_nx = addr[RD_BIT];
                    cs_nx      = 1'b0;
                    busy_nx    = 1'b1;
                    mosi_nx    = addr[ADDR_WIDTH-1];
                    pcnt_nx    = '0;
                    state_nx   = SETUP;
                end
            end
            SETUP: begin
                if (pcnt == PW'(CS_SETUP - 1)) begin
                    hcnt_nx  = '0;
                    bcnt_nx  = '0;
                    state_nx = SHIFT;
                end else begin
                    pcnt_nx = pcnt + 1'b1;
                end
            end
            SHIFT: begin
                if (hcnt != HW'(CLK_DIV - 1)) begin
                    hcnt_nx = hcnt + 1'b1;
                end else begin
                    hcnt_nx = '0;
                    if (!spi_sck) begin
                        // rising edge: sample data-phase miso on reads
                        sck_nx = 1'b1;
                        if (is_read && bcnt >= BW'(ADDR_WIDTH))
                            rxsh_nx = {rxsh[DATA_WIDTH-2:0], miso_s};
                    end else if (bcnt == BW'(N - 1)) begin
                        sck_nx   = 1'b0;
                        mosi_nx  = 1'b0;
                        pcnt_nx  = '0;
                        state_nx = HOLD;
                    end else begin
                        sck_nx   = 1'b0;
                        bcnt_nx  = bcnt + 1'b1;
                        shreg_nx = {shreg[N-2:0], 1'b0};
                        mosi_nx  = (is_read && bcnt_nx >= BW'(ADDR_WIDTH)) ? 1'b0 : shreg[N-2];
                    end
                end
            end
            HOLD: begin
                if (pcnt == PW'(CS_HOLD - 1)) begin
                    cs_nx    = 1'b1;
                    done_nx  = 1'b1;
                    pcnt_nx  = '0;
                    state_nx = GAP;
                    if (is_read)
                        rxdata_nx = rxsh;
                end else begin
                    pcnt_nx = pcnt + 1'b1;
                end
            end
            GAP: begin
                // the first idle cycle is the last CS-high cycle of the gap
                if (pcnt == PW'(CS_GAP - 2)) begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    pcnt_nx = pcnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hcnt     <= '0;
            bcnt     <= '0;
            pcnt     <= '0;
            shreg    <= '0;
            rxsh     <= '0;
            rxdata   <= '0;
            is_read  <= 1'b0;
            spi_cs   <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            hcnt     <= hcnt_nx;
            bcnt     <= bcnt_nx;
            pcnt     <= pcnt_nx;
            shreg    <= shreg_nx;
            rxsh     <= rxsh_nx;
            rxdata   <= rxdata_nx;
            is_read  <= is_read_nx;
            spi_cs   <= cs_nx;
            spi_sck  <= sck_nx;
            spi_mosi <= mosi_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: write/read frames, timing, start-while-busy,
// back-to-back frames and reset mid-frame, against a simple responder model.
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] txdata = '0;
    logic        busy, done, spi_cs, spi_sck, spi_mosi, spi_miso;
    logic [15:0] rxdata;

    int total = 0;
    int bad   = 0;

    spi_master dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .addr     (addr),
        .txdata   (txdata),
        .busy     (busy),
        .done     (done),
        .rxdata   (rxdata),
        .spi_cs   (spi_cs),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;

    // responder: launches data bit on each falling edge after the address, delayed in its clock domain
    logic [15:0] resp = 16'h0;
    logic        sck_q = 1'b0;
    logic        want = 1'b0;
    logic [2:0]  dly = 3'b0;
    int          fc = 0;

    always @(posedge clk) begin
        sck_q <= spi_sck;
        if (spi_cs) begin
            fc   <= 0;
            want <= 1'b0;
        end else if (sck_q && !spi_sck) begin
            fc <= fc + 1;
            if (fc >= 7 && fc <= 22)
                want <= resp[22 - fc];
        end
        dly <= {dly[1:0], want};
    end
    assign spi_miso = dly[2];

    // line monitor, sampled mid-cycle
    int          cyc = 0, cs_fall_t = 0, cs_rise_t = 0, first_rise_t = 0, last_rise_t = 0;
    int          last_fall_t = 0, rises = 0, dones = 0, falls = 0, gap_len = 0;
    int          min_per = 0, max_per = 0;
    logic [23:0] mosi_cap = '0;
    logic [15:0] done_rx = '0;
    logic        sck_p = 1'b0, cs_p = 1'b1;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cs_p && !spi_cs) begin
            gap_len   = cyc - cs_rise_t;
            cs_fall_t = cyc;
            rises     = 0;
            mosi_cap  = '0;
            min_per   = 1000;
            max_per   = 0;
            falls     = falls + 1;
        end
        if (!cs_p && spi_cs)
            cs_rise_t = cyc;
        if (!sck_p && spi_sck) begin
            if (rises == 0) begin
                first_rise_t = cyc;
            end else begin
                if (cyc - last_rise_t < min_per) min_per = cyc - last_rise_t;
                if (cyc - last_rise_t > max_per) max_per = cyc - last_rise_t;
            end
            last_rise_t = cyc;
            rises       = rises + 1;
            mosi_cap    = {mosi_cap[22:0], spi_mosi};
        end
        if (sck_p && !spi_sck)
            last_fall_t = cyc;
        if (done) begin
            dones   = dones + 1;
            done_rx = rxdata;
        end
        sck_p = spi_sck;
        cs_p  = spi_cs;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic kick(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        addr   = a;
        txdata = d;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic finish_frame(input int d0);
        int k = 0;
        while ((dones <= d0 || busy) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("frame_timeout", (k < 2000), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int d0, f0, k;

        repeat (3) @(negedge clk);
        chk("rst_cs",   spi_cs,   1);
        chk("rst_sck",  spi_sck,  0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_busy", busy,     0);
        chk("rst_done", done,     0);
        chk("rst_rx",   rxdata,   0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // write frame plus timing
        d0 = dones;
        kick(8'h12, 16'hABCD);
        chk("wr_busy", busy, 1);
        finish_frame(d0);
        chk("wr_mosi",   mosi_cap, 24'h12ABCD);
        chk("wr_cs_len", cs_rise_t - cs_fall_t, 392);
        chk("wr_dones",  dones - d0, 1);
        chk("wr_rx",     rxdata, 0);
        chk("t_first",   first_rise_t - cs_fall_t, 12);
        chk("t_hold",    cs_rise_t - last_fall_t, 4);
        chk("t_rises",   rises, 24);
        chk("t_pmin",    min_per, 16);
        chk("t_pmax",    max_per, 16);

        // read frame
        resp = 16'h5A5A;
        d0 = dones;
        kick(8'h85, 16'hFFFF);
        finish_frame(d0);
        chk("rd_mosi",   mosi_cap, 24'h850000);
        chk("rd_donerx", done_rx, 16'h5A5A);
        chk("rd_rx",     rxdata, 16'h5A5A);

        // start while busy is ignored
        d0 = dones;
        f0 = falls;
        kick(8'h3C, 16'h0F0F);
        repeat (100) @(negedge clk);
        addr  = 8'h99;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_frame(d0);
        repeat (20) @(negedge clk);
        chk("mid_dones", dones - d0, 1);
        chk("mid_falls", falls - f0, 1);
        chk("mid_mosi",  mosi_cap, 24'h3C0F0F);
        chk("mid_rx",    rxdata, 16'h5A5A);

        // back-to-back with start held
        d0 = dones;
        f0 = falls;
        @(negedge clk);
        addr   = 8'h34;
        txdata = 16'h5678;
        start  = 1'b1;
        k = 0;
        while (falls - f0 < 2 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("b2b_timeout", (k < 2000), 1);
        chk("b2b_gap", gap_len, 4);
        finish_frame(d0 + 1);
        chk("b2b_falls", falls - f0, 2);
        chk("b2b_dones", dones - d0, 2);
        chk("b2b_mosi",  mosi_cap, 24'h345678);

        // reset during bit 10 of a read
        resp = 16'hC3C3;
        kick(8'h85, 16'h0000);
        k = 0;
        while (rises != 11 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("rr_timeout", (k < 2000), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rr_cs",   spi_cs,  1);
        chk("rr_sck",  spi_sck, 0);
        chk("rr_busy", busy,    0);
        chk("rr_rx",   rxdata,  0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        resp = 16'h1234;
        d0 = dones;
        kick(8'h81, 16'hAAAA);
        finish_frame(d0);
        chk("rr2_mosi", mosi_cap, 24'h810000);
        chk("rr2_rx",   rxdata, 16'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
